// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit controller slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, header nibble, clog2 helper.
package uart_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    GUARD     = 3'd4,
    HDR_ISSUE = 3'd5
  } state_t;

  // Upper nibble of the requester-ID header frame.
  localparam logic [3:0] HDR_NIBBLE = 4'hA;

  // Width needed to index n items; never less than 1 bit.
  function automatic int clog2(input int n);
    int w;
    for (w = 1; (1 << w) < n; w++) begin
    end
    return w;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running baud tick generator: one-cycle tick every CLKS_PER_BIT clocks.
// Latency: first tick CLKS_PER_BIT cycles after rst deasserts.
// Backpressure: none; runs continuously regardless of downstream state.
// Ports: clk, rst (sync, active-high), tick (out, one-cycle pulse).
module uart_baud_gen
  import uart_ctrl_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CW'(CLKS_PER_BIT - 1));
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one uart_tx between NUM_REQ byte requesters, with baud tick and stop-bit guard.
// Latency: accept at cycle t -> uart_send at t+1; accepts spaced by >= one frame + GUARD_TICKS ticks.
// Backpressure: req_ready is a one-cycle strobe issued only in IDLE; req_valid is ignored elsewhere.
// Ports: clk/rst; req_valid/req_data/req_ready (requester side); tx_en/uart_send/uart_data/uart_busy
//        (uart_tx side); grant_id (last accepted index); active (FSM not in IDLE).
// Build option: UART_ARB_ID_HDR_EN prefixes each grant with a header frame {A, 0, id[2:0]}.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 868,
  parameter int GUARD_TICKS  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*8-1:0]      req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_en,
  output logic                      uart_send,
  output logic [7:0]                uart_data,
  input  logic                      uart_busy,
  output logic [clog2(NUM_REQ)-1:0] grant_id,
  output logic                      active
);

  localparam int IDW = clog2(NUM_REQ);
  localparam int GW  = clog2(GUARD_TICKS + 1);

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [7:0]       data_q, data_d;
  logic [GW-1:0]    guard_q, guard_d;
`ifdef UART_ARB_ID_HDR_EN
  logic             phase_q, phase_d;  // 1: header frame still to go
`endif

  logic             found;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   idx;

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tx_en)
  );

  // Descending scan so the requester nearest the pointer is assigned last and wins.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = ptr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr_q) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    data_d    = data_q;
    guard_d   = guard_q;
    req_ready = '0;
`ifdef UART_ARB_ID_HDR_EN
    phase_d   = phase_q;
`endif
    case (state_q)
      IDLE: begin
        // rst gate keeps a grant from being strobed in a cycle that will be discarded.
        if (found && !rst) begin
          req_ready[win] = 1'b1;
          data_d         = req_data[win*8 +: 8];
          grant_d        = win;
          ptr_d          = (win == IDW'(NUM_REQ - 1)) ? '0 : win + IDW'(1);
`ifdef UART_ARB_ID_HDR_EN
          phase_d        = 1'b1;
          state_d        = HDR_ISSUE;
`else
          state_d        = ISSUE;
`endif
        end
      end
`ifdef UART_ARB_ID_HDR_EN
      HDR_ISSUE: state_d = WAIT_BUSY;
`endif
      ISSUE:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (uart_busy)  state_d = WAIT_DONE;
      WAIT_DONE: if (!uart_busy) state_d = GUARD;
      GUARD: begin
        // uart_tx drops busy on the tick that drives the stop bit, so the guard
        // supplies the stop-bit time before the line can start another frame.
        if (tx_en) begin
          if (guard_q <= GW'(1)) begin
            guard_d = GW'(GUARD_TICKS);
`ifdef UART_ARB_ID_HDR_EN
            if (phase_q) begin
              phase_d = 1'b0;
              state_d = ISSUE;
            end else begin
              state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
          end else begin
            guard_d = guard_q - GW'(1);
          end
        end
      end
      default: state_d = WAIT_DONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // uart_tx has no reset and may still be mid-frame, so resynchronise via WAIT_DONE.
      state_q <= WAIT_DONE;
      ptr_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      guard_q <= GW'(GUARD_TICKS);
`ifdef UART_ARB_ID_HDR_EN
      phase_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      guard_q <= guard_d;
`ifdef UART_ARB_ID_HDR_EN
      phase_q <= phase_d;
`endif
    end
  end

  assign grant_id = grant_q;
  assign active   = (state_q != IDLE);

`ifdef UART_ARB_ID_HDR_EN
  assign uart_send = (state_q == ISSUE) || (state_q == HDR_ISSUE);
  assign uart_data = phase_q ? {HDR_NIBBLE, 1'b0, 3'(grant_q)} : data_q;
`else
  assign uart_send = (state_q == ISSUE);
  assign uart_data = data_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_tx on the line side.
// Latency: n/a.
// Backpressure: producers hold req_valid until accepted, then drop it.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int CPB     = 4;
  localparam int GT      = 2;
`ifdef UART_ARB_ID_HDR_EN
  localparam int FPG = 2;
`else
  localparam int FPG = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data  = '0;
  logic [3:0]  req_ready;
  logic        tx_en;
  logic        uart_send;
  logic [7:0]  uart_data;
  logic        uart_busy;
  logic [1:0]  grant_id;
  logic        active;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .CLKS_PER_BIT(CPB), .GUARD_TICKS(GT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_en     (tx_en),
    .uart_send (uart_send),
    .uart_data (uart_data),
    .uart_busy (uart_busy),
    .grant_id  (grant_id),
    .active    (active)
  );

  // Cycle count advances on the falling edge so rising-edge samplers all see one value.
  int cyc = 0;
  always @(negedge clk) cyc <= cyc + 1;

  // Behavioural uart_tx (no reset): start bit, 8 data bits LSB first, stop bit;
  // busy drops on the tick that drives the stop bit.
  logic       m_busy = 1'b0;
  logic       tx_line = 1'b1;
  logic [3:0] m_pos = '0;
  logic [7:0] m_sh = '0;
  logic [7:0] m_rx = '0;
  logic [9:0] line_hist = '0;
  int         bf_cyc = 0;
  logic [7:0] frames[$];

  assign uart_busy = m_busy;

  always @(posedge clk) begin
    logic nb;
    if (!m_busy) begin
      if (uart_send) begin
        m_sh   <= uart_data;
        m_busy <= 1'b1;
        m_pos  <= '0;
      end
    end else if (tx_en) begin
      if (m_pos == 4'd0) nb = 1'b0;
      else if (m_pos <= 4'd8) nb = m_sh[3'(m_pos - 4'd1)];
      else nb = 1'b1;
      tx_line   <= nb;
      line_hist <= {line_hist[8:0], nb};
      if (m_pos >= 4'd1 && m_pos <= 4'd8) m_rx <= {nb, m_rx[7:1]};
      if (m_pos == 4'd9) begin
        m_busy <= 1'b0;
        bf_cyc <= cyc;
        frames.push_back(m_rx);
      end
      m_pos <= m_pos + 4'd1;
    end
  end

  // Accept monitor.
  int acc_id[$];
  int acc_cyc[$];
  int n_ready_cyc = 0;
  int bad_onehot = 0;
  always @(posedge clk) begin
    if (|req_ready) n_ready_cyc++;
    if (!$onehot0(req_ready)) bad_onehot++;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!rst && req_valid[i] && req_ready[i]) begin
        acc_id.push_back(i);
        acc_cyc.push_back(cyc);
      end
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int n, input int budget, input string tag);
    int t = 0;
    while (acc_id.size() < n && t < budget) begin
      step();
      t++;
    end
    chk(tag, 32'(acc_id.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int t = 0;
    while (active !== 1'b0 && t < budget) begin
      step();
      t++;
    end
    chk(tag, 32'(active), 32'd0);
  endtask

  initial begin
    int exp_ids[5];
    int t;
    exp_ids = '{0, 1, 2, 3, 0};

    // ---- Reset state and first baud tick ----
    rst = 1'b1;
    repeat (3) step();
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_tx_en", 32'(tx_en), 32'h0);
    chk("rst_send", 32'(uart_send), 32'h0);
    chk("rst_data", 32'(uart_data), 32'h0);
    chk("rst_grant", 32'(grant_id), 32'h0);
    chk("rst_active", 32'(active), 32'h1);
    rst = 1'b0;
    step(); step();
    chk("tick_early", 32'(tx_en), 32'h0);
    step();
    chk("tick_first", 32'(tx_en), 32'h1);
    step();
    chk("tick_single", 32'(tx_en), 32'h0);
    step(); step(); step();
    chk("guard_active", 32'(active), 32'h1);
    step();
    chk("guard_done", 32'(active), 32'h0);
    chk("idle_line", 32'(tx_line), 32'h1);
    step();
    chk("no_req_ready", 32'(req_ready), 32'h0);
    chk("no_req_idle", 32'(active), 32'h0);

    // ---- Requester 2 sends 0x55 ----
    req_data[23:16] = 8'h55;
    req_valid = 4'b0100;
    #1;
    chk("r2_ready", 32'(req_ready), 32'h4);
    step();
    chk("r2_send", 32'(uart_send), 32'h1);
    chk("r2_grant", 32'(grant_id), 32'h2);
    chk("r2_data", 32'(uart_data), 32'h55);
    chk("r2_ready_drop", 32'(req_ready), 32'h0);
    req_valid = '0;
    step();
    chk("r2_send_once", 32'(uart_send), 32'h0);
    wait_idle(300, "r2_idle_timeout");
`ifndef UART_ARB_ID_HDR_EN
    chk("r2_line_bits", 32'(line_hist), 32'h155);
`endif
    chk("r2_frame", 32'(frames.size() > 0 ? frames[$] : 8'h00), 32'h55);
    chk("r2_stop_guard", 32'(cyc - bf_cyc), 32'd8);
    chk("r2_accepts", 32'(acc_id.size()), 32'd1);

    // ---- All four valid from reset: rotation and spacing ----
    acc_id.delete(); acc_cyc.delete(); frames.delete();
    req_data  = 32'h13121110;
    req_valid = 4'hF;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    wait_acc(5, 800, "rr_timeout");
    req_valid = '0;
    wait_idle(400, "rr_idle_timeout");
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr_id%0d", k), 32'(acc_id.size() > k ? acc_id[k] : -1), 32'(exp_ids[k]));
      chk($sformatf("rr_frame%0d", k),
          32'(frames.size() > k*FPG + FPG - 1 ? frames[k*FPG + FPG - 1] : 8'h00),
          32'(8'h10 + exp_ids[k]));
    end
    for (int k = 1; k < 5; k++) begin
      chk($sformatf("rr_gap%0d", k), 32'(acc_cyc.size() > k ? acc_cyc[k] - acc_cyc[k-1] : 0),
          32'(48 * FPG));
    end

    // ---- Requester 1 alone, then 0 and 1 together (pointer wraps) ----
    acc_id.delete(); acc_cyc.delete();
    req_data  = 32'h00002130;
    req_valid = 4'b0010;
    wait_acc(1, 100, "wrap_t1");
    chk("wrap_first", 32'(acc_id.size() > 0 ? acc_id[0] : -1), 32'd1);
    req_valid = 4'b0011;
    step();
    chk("busy_ignores_valid", 32'(req_ready), 32'h0);
    wait_acc(2, 300, "wrap_t2");
    chk("wrap_second", 32'(acc_id.size() > 1 ? acc_id[1] : -1), 32'd0);
    wait_acc(3, 300, "wrap_t3");
    req_valid = '0;
    chk("wrap_third", 32'(acc_id.size() > 2 ? acc_id[2] : -1), 32'd1);
    wait_idle(300, "wrap_idle_timeout");
    chk("wrap_last_frame", 32'(frames.size() > 0 ? frames[$] : 8'h00), 32'h21);

    // ---- Reset mid data bit 3 with requester 0 pending ----
    acc_id.delete(); acc_cyc.delete();
    req_data  = 32'h0000005A;
    req_valid = 4'b0001;
    wait_acc(1, 100, "mid_t1");
    req_data = 32'h00000077;
    t = 0;
    while (!(m_busy && m_pos == 4'd5) && t < 200) begin
      step();
      t++;
    end
    chk("mid_reach_bit3", 32'(m_busy && m_pos == 4'd5), 32'd1);
    rst = 1'b1;
    step();
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    chk("mid_rst_send", 32'(uart_send), 32'h0);
    chk("mid_rst_data", 32'(uart_data), 32'h0);
    chk("mid_rst_grant", 32'(grant_id), 32'h0);
    chk("mid_rst_active", 32'(active), 32'h1);
    chk("mid_rst_tx_en", 32'(tx_en), 32'h0);
    rst = 1'b0;
    wait_acc(2, 300, "mid_t2");
    req_valid = '0;
    chk("mid_resync_gap", 32'(acc_cyc.size() > 1 ? acc_cyc[1] - bf_cyc : 0), 32'd9);
    chk("mid_regrant", 32'(acc_id.size() > 1 ? acc_id[1] : -1), 32'd0);
    wait_idle(300, "mid_idle_timeout");
    chk("mid_frame", 32'(frames.size() > 0 ? frames[$] : 8'h00), 32'h77);
    chk("mid_grant_id", 32'(grant_id), 32'h0);

    // ---- Requester 3 sends 0xC3 (header frame when enabled) ----
    acc_id.delete(); acc_cyc.delete(); frames.delete();
    n_ready_cyc = 0;
    req_data  = 32'hC3000000;
    req_valid = 4'b1000;
    wait_acc(1, 100, "hdr_t1");
    req_valid = '0;
    wait_idle(400, "hdr_idle_timeout");
    chk("hdr_strobes", 32'(n_ready_cyc), 32'd1);
    chk("hdr_nframes", 32'(frames.size()), 32'(FPG));
`ifdef UART_ARB_ID_HDR_EN
    chk("hdr_frame0", 32'(frames.size() > 0 ? frames[0] : 8'h00), 32'hA3);
    chk("hdr_frame1", 32'(frames.size() > 1 ? frames[1] : 8'h00), 32'hC3);
`else
    chk("hdr_frame0", 32'(frames.size() > 0 ? frames[0] : 8'h00), 32'hC3);
`endif
    chk("ready_onehot", 32'(bad_onehot), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
